blob_metrics: RTL and testbench
===============================

BLOB_METRICS -- requirements
Module: blob_metrics

Interface
REQ-001 The block SHALL have parameter WIDTH, default 180, which is the frame width in pixels.
REQ-002 The block SHALL have parameter HEIGHT, default 320, which is the frame height in pixels.
REQ-003 Port clk_in, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst_in, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port pixel_valid_in, input, 1 bit: a mask pixel is presented this cycle.
REQ-006 Port mask_in, input, 1 bit: 1 means the pixel belongs to the object.
REQ-007 Port hcount_in, input, $clog2(WIDTH) bits: pixel column, 0..WIDTH-1.
REQ-008 Port vcount_in, input, $clog2(HEIGHT) bits: pixel row, 0..HEIGHT-1.
REQ-009 Port busy_in, input, 1 bit: the downstream circularity divider is busy.
REQ-010 Port area_out, output, $clog2(WIDTH*HEIGHT)+1 bits: object pixel count for the frame.
REQ-011 Port perimeter_out, output, $clog2(WIDTH*HEIGHT)+1 bits: boundary edge count for the frame.
REQ-012 Port data_valid_out, output, 1 bit: one-cycle strobe that issues area_out/perimeter_out downstream.
REQ-013 Port overrun_out, output, 1 bit: sticky flag, set when a frame result was overwritten before it was issued.

Function
REQ-014 Pixels SHALL arrive in raster order, and the block SHALL process only cycles where pixel_valid_in=1; pixel (0,0) SHALL clear the running accumulators.
REQ-015 Area SHALL increase by 1 for each pixel with mask_in=1.
REQ-016 Each pixel SHALL add the following to the perimeter:
- (m != left), where left = 0 at hcount=0;
- plus (m && hcount==WIDTH-1);
- plus (m != up), where up = 0 at vcount=0;
- plus (m && vcount==HEIGHT-1).
REQ-017 The "up" bit SHALL come from a WIDTH-bit line buffer holding the previous row, written at index hcount with each accepted pixel.
REQ-018 Both accumulators SHALL saturate at all-ones and never wrap.
REQ-019 The state machine SHALL have states ACCUM, ISSUE and PEND, and SHALL reset to ACCUM.
REQ-020 State transitions:
- ACCUM -> ISSUE when pixel (WIDTH-1,HEIGHT-1) is accepted; final totals are latched into area_out/perimeter_out on that same edge.
- ISSUE with busy_in=0: data_valid_out=1 for exactly one cycle, then -> ACCUM.
- ISSUE with busy_in=1: -> PEND, data_valid_out=0.
- PEND: hold outputs stable; when busy_in=0, pulse data_valid_out for one cycle, then -> ACCUM.
REQ-021 Latency SHALL be as follows: the last pixel is accepted at edge N, and data_valid_out is high in the cycle after edge N+1 when busy_in=0.
REQ-022 Pixels SHALL continue to be accumulated for the next frame while in ISSUE or PEND.
REQ-023 If the next frame completes while in PEND, the newer totals SHALL overwrite the outputs, overrun_out SHALL be set, and the block SHALL stay in PEND.
REQ-024 area_out and perimeter_out SHALL change only on frame-completion latch.
REQ-025 A pixel with pixel_valid_in=0 SHALL have no effect; out-of-range hcount/vcount SHALL be ignored.

Reset
REQ-026 When rst_in=0, the block SHALL immediately (asynchronously) clear area_out, perimeter_out, data_valid_out, overrun_out, the accumulators and the line buffer, and set state to ACCUM.
REQ-027 Reset mid-frame SHALL discard the partial frame, and the block SHALL not emit any strobe until a full subsequent frame completes.
REQ-028 overrun_out SHALL clear only on reset.

Configuration
REQ-029 Macro BLOB_METRICS_BBOX_EN: when defined, the block SHALL add outputs x_min_out and x_max_out ($clog2(WIDTH) bits) and y_min_out and y_max_out ($clog2(HEIGHT) bits).
REQ-030 With BLOB_METRICS_BBOX_EN defined, the bounding-box outputs SHALL be the bounding box of mask pixels, latched alongside area_out.
REQ-031 With BLOB_METRICS_BBOX_EN defined and an empty frame, the bounding-box outputs SHALL be min=all-ones and max=0.
REQ-032 Without BLOB_METRICS_BBOX_EN, the bounding-box ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 All-zero frame, busy_in=0 -> exactly one data_valid_out pulse with area_out=0 and perimeter_out=0.
REQ-034 Single mask pixel at (50,100) -> area_out=1, perimeter_out=4; with BBOX_EN, x_min=x_max=50 and y_min=y_max=100.
REQ-035 10x10 square at (20..29, 30..39) -> area_out=100, perimeter_out=40, data_valid_out 2 cycles after the last pixel.
REQ-036 Full-ones frame (180x320) -> area_out=57600, perimeter_out=1000.
REQ-037 busy_in held 1 for 50 cycles after frame end -> no strobe; outputs stable; one pulse in the cycle after busy_in falls.
REQ-038 rst_in low mid-frame, then one 10x10-square frame -> no strobe for the aborted frame; a single strobe with 100/40; overrun_out=0.

Source files
------------

// File: rtl/blob_metrics.sv
// Per-frame area and boundary-edge perimeter of a raster-scanned binary mask, issued downstream with a busy handshake.
// Optional bounding-box outputs are enabled with `define BLOB_METRICS_BBOX_EN.
module blob_metrics #(
   parameter int WIDTH  = 180,
   parameter int HEIGHT = 320
) (
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic                             pixel_valid_in,
   input  logic                             mask_in,
   input  logic [$clog2(WIDTH)-1:0]         hcount_in,
   input  logic [$clog2(HEIGHT)-1:0]        vcount_in,
   input  logic                             busy_in,
   output logic [$clog2(WIDTH*HEIGHT):0]    area_out,
   output logic [$clog2(WIDTH*HEIGHT):0]    perimeter_out,
   output logic                             data_valid_out,
   output logic                             overrun_out
`ifdef BLOB_METRICS_BBOX_EN
   ,
   output logic [$clog2(WIDTH)-1:0]         x_min_out,
   output logic [$clog2(WIDTH)-1:0]         x_max_out,
   output logic [$clog2(HEIGHT)-1:0]        y_min_out,
   output logic [$clog2(HEIGHT)-1:0]        y_max_out
`endif
);

   localparam int HW = $clog2(WIDTH);
   localparam int VW = $clog2(HEIGHT);
   localparam int AW = $clog2(WIDTH*HEIGHT) + 1;
   localparam logic [HW-1:0] X_LAST = HW'(WIDTH - 1);
   localparam logic [VW-1:0] Y_LAST = VW'(HEIGHT - 1);

   localparam logic [1:0] ACCUM = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] PEND  = 2'd2;

   function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a, input logic [2:0] b);
      logic [AW:0] sum;
      sum = {1'b0, a} + {{(AW-2){1'b0}}, b};
      if (sum[AW]) begin
         return {AW{1'b1}};
      end else begin
         return sum[AW-1:0];
      end
   endfunction

   logic [1:0]    state_r;
   logic [WIDTH-1:0] line_buf_r;
   logic          left_r;
   logic          started_r;
   logic [AW-1:0] area_acc_r;
   logic [AW-1:0] perim_acc_r;

   logic          accept_s;
   logic          first_s;
   logic          last_s;
   logic          left_s;
   logic          up_s;
   logic [2:0]    inc_s;
   logic [AW-1:0] area_next_s;
   logic [AW-1:0] perim_next_s;
`ifdef BLOB_METRICS_BBOX_EN
   logic [HW-1:0] x_min_r, x_max_r, x_min_next_s, x_max_next_s;
   logic [VW-1:0] y_min_r, y_max_r, y_min_next_s, y_max_next_s;
`endif

   // Per-pixel decode: neighbour bits, perimeter increment and next running totals.
   always_comb begin
      accept_s = pixel_valid_in && (hcount_in <= X_LAST) && (vcount_in <= Y_LAST);
      first_s  = accept_s && (hcount_in == {HW{1'b0}}) && (vcount_in == {VW{1'b0}});
      // A frame only completes if its (0,0) was seen since reset.
      last_s   = accept_s && (hcount_in == X_LAST) && (vcount_in == Y_LAST) && (started_r || first_s);
      if (hcount_in == {HW{1'b0}}) begin
         left_s = 1'b0;
      end else begin
         left_s = left_r;
      end
      if (vcount_in == {VW{1'b0}}) begin
         up_s = 1'b0;
      end else begin
         up_s = line_buf_r[hcount_in];
      end
      inc_s = {2'b00, mask_in ^ left_s} + {2'b00, mask_in && (hcount_in == X_LAST)}
            + {2'b00, mask_in ^ up_s}   + {2'b00, mask_in && (vcount_in == Y_LAST)};
      if (first_s) begin
         area_next_s  = sat_add({AW{1'b0}}, {2'b00, mask_in});
         perim_next_s = sat_add({AW{1'b0}}, inc_s);
      end else begin
         area_next_s  = sat_add(area_acc_r, {2'b00, mask_in});
         perim_next_s = sat_add(perim_acc_r, inc_s);
      end
`ifdef BLOB_METRICS_BBOX_EN
      if (first_s) begin
         x_min_next_s = {HW{1'b1}};
         x_max_next_s = {HW{1'b0}};
         y_min_next_s = {VW{1'b1}};
         y_max_next_s = {VW{1'b0}};
      end else begin
         x_min_next_s = x_min_r;
         x_max_next_s = x_max_r;
         y_min_next_s = y_min_r;
         y_max_next_s = y_max_r;
      end
      if (mask_in) begin
         if (hcount_in < x_min_next_s) x_min_next_s = hcount_in; else x_min_next_s = x_min_next_s;
         if (hcount_in > x_max_next_s) x_max_next_s = hcount_in; else x_max_next_s = x_max_next_s;
         if (vcount_in < y_min_next_s) y_min_next_s = vcount_in; else y_min_next_s = y_min_next_s;
         if (vcount_in > y_max_next_s) y_max_next_s = vcount_in; else y_max_next_s = y_max_next_s;
      end else begin
         x_min_next_s = x_min_next_s;
      end
`endif
   end

   // Running accumulators and previous-row line buffer.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         line_buf_r  <= {WIDTH{1'b0}};
         left_r      <= 1'b0;
         started_r   <= 1'b0;
         area_acc_r  <= {AW{1'b0}};
         perim_acc_r <= {AW{1'b0}};
`ifdef BLOB_METRICS_BBOX_EN
         x_min_r <= {HW{1'b1}};
         x_max_r <= {HW{1'b0}};
         y_min_r <= {VW{1'b1}};
         y_max_r <= {VW{1'b0}};
`endif
      end else if (accept_s) begin
         line_buf_r[hcount_in] <= mask_in;
         left_r      <= mask_in;
         started_r   <= started_r | first_s;
         area_acc_r  <= area_next_s;
         perim_acc_r <= perim_next_s;
`ifdef BLOB_METRICS_BBOX_EN
         x_min_r <= x_min_next_s;
         x_max_r <= x_max_next_s;
         y_min_r <= y_min_next_s;
         y_max_r <= y_max_next_s;
`endif
      end else begin
         left_r <= left_r;
      end
   end

   // Frame results change only when a frame completes.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         area_out      <= {AW{1'b0}};
         perimeter_out <= {AW{1'b0}};
`ifdef BLOB_METRICS_BBOX_EN
         x_min_out <= {HW{1'b0}};
         x_max_out <= {HW{1'b0}};
         y_min_out <= {VW{1'b0}};
         y_max_out <= {VW{1'b0}};
`endif
      end else if (last_s) begin
         area_out      <= area_next_s;
         perimeter_out <= perim_next_s;
`ifdef BLOB_METRICS_BBOX_EN
         x_min_out <= x_min_next_s;
         x_max_out <= x_max_next_s;
         y_min_out <= y_min_next_s;
         y_max_out <= y_max_next_s;
`endif
      end else begin
         area_out <= area_out;
      end
   end

   // Issue handshake; a completion before the pending result left marks an overrun.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_r        <= ACCUM;
         data_valid_out <= 1'b0;
         overrun_out    <= 1'b0;
      end else begin
         data_valid_out <= 1'b0;
         case (state_r)
            ACCUM: begin
               if (last_s) state_r <= ISSUE; else state_r <= ACCUM;
            end
            ISSUE: begin
               if (last_s) begin
                  overrun_out <= 1'b1;
                  state_r     <= PEND;
               end else if (busy_in) begin
                  state_r <= PEND;
               end else begin
                  data_valid_out <= 1'b1;
                  state_r        <= ACCUM;
               end
            end
            PEND: begin
               if (last_s) begin
                  overrun_out <= 1'b1;
               end else if (!busy_in) begin
                  data_valid_out <= 1'b1;
                  state_r        <= ACCUM;
               end else begin
                  state_r <= PEND;
               end
            end
            default: state_r <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_blob_metrics.sv
// Randomized self-checking bench for blob_metrics on a reduced frame, checked every cycle against an image-level model.
module tb_blob_metrics;
   localparam int W  = 52;
   localparam int H  = 102;
   localparam int HB = $clog2(W);
   localparam int VB = $clog2(H);
   localparam int AB = $clog2(W*H) + 1;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b0;
   logic          pixel_valid_in = 1'b0;
   logic          mask_in = 1'b0;
   logic [HB-1:0] hcount_in = '0;
   logic [VB-1:0] vcount_in = '0;
   logic          busy_in = 1'b0;
   logic [AB-1:0] area_out, perimeter_out;
   logic          data_valid_out, overrun_out;
`ifdef BLOB_METRICS_BBOX_EN
   logic [HB-1:0] x_min_out, x_max_out, exp_xmin = '0, exp_xmax = '0;
   logic [VB-1:0] y_min_out, y_max_out, exp_ymin = '0, exp_ymax = '0;
`endif

   blob_metrics #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .pixel_valid_in(pixel_valid_in), .mask_in(mask_in),
      .hcount_in(hcount_in), .vcount_in(vcount_in), .busy_in(busy_in),
      .area_out(area_out), .perimeter_out(perimeter_out),
      .data_valid_out(data_valid_out), .overrun_out(overrun_out)
`ifdef BLOB_METRICS_BBOX_EN
      , .x_min_out(x_min_out), .x_max_out(x_max_out), .y_min_out(y_min_out), .y_max_out(y_max_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   bit            img [H][W];
   int            errors = 0, checks = 0, dv_count = 0;
   bit            check_en = 1'b0;
   logic [AB-1:0] exp_area = '0, exp_perim = '0;
   logic          exp_overrun = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Image-level model: perimeter = 4*area - 2*(4-connected mask pairs).
   function automatic void model(output int area, output int perim,
                                 output int xmin, output int xmax, output int ymin, output int ymax);
      int pairs = 0;
      area = 0; xmin = (1 << HB) - 1; xmax = 0; ymin = (1 << VB) - 1; ymax = 0;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            if (img[y][x]) begin
               area++;
               if (x > 0 && img[y][x-1]) pairs++;
               if (y > 0 && img[y-1][x]) pairs++;
               if (x < xmin) xmin = x;
               if (x > xmax) xmax = x;
               if (y < ymin) ymin = y;
               if (y > ymax) ymax = y;
            end
         end
      end
      perim = 4*area - 2*pairs;
      if (area > (1 << AB) - 1) area = (1 << AB) - 1;
      if (perim > (1 << AB) - 1) perim = (1 << AB) - 1;
   endfunction

   // Per-cycle comparison of all outputs against the latest modelled result.
   always @(negedge clk_in) begin
      if (check_en) begin
         check("area_out", 32'(area_out), 32'(exp_area));
         check("perimeter_out", 32'(perimeter_out), 32'(exp_perim));
         check("overrun_out", 32'(overrun_out), 32'(exp_overrun));
`ifdef BLOB_METRICS_BBOX_EN
         check("x_min", 32'(x_min_out), 32'(exp_xmin));
         check("x_max", 32'(x_max_out), 32'(exp_xmax));
         check("y_min", 32'(y_min_out), 32'(exp_ymin));
         check("y_max", 32'(y_max_out), 32'(exp_ymax));
`endif
         if (data_valid_out) dv_count++;
      end
   end

   task automatic present(input int x, input int y, input bit m, input bit v);
      @(posedge clk_in); #1;
      pixel_valid_in = v; mask_in = m; hcount_in = HB'(x); vcount_in = VB'(y);
   endtask

   task automatic junk();
      int r = $urandom_range(0, 2);
      case (r)
         0: present($urandom_range(0, W-1), $urandom_range(0, H-1), 1'($urandom_range(0, 1)), 1'b0);
         1: present($urandom_range(W, (1 << HB) - 1), $urandom_range(0, H-1), 1'b1, 1'b1);
         default: present($urandom_range(0, W-1), $urandom_range(H, (1 << VB) - 1), 1'b1, 1'b1);
      endcase
   endtask

   task automatic send_frame(input int junk_pct, input bit set_overrun);
      int a, p, x0, x1, y0, y1;
      model(a, p, x0, x1, y0, y1);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            if (junk_pct > 0 && $urandom_range(0, 99) < junk_pct) junk();
            present(x, y, img[y][x], 1'b1);
         end
      end
      @(posedge clk_in); #1;
      pixel_valid_in = 1'b0;
      exp_area = AB'(a); exp_perim = AB'(p);
      if (set_overrun) exp_overrun = 1'b1;
`ifdef BLOB_METRICS_BBOX_EN
      exp_xmin = HB'(x0); exp_xmax = HB'(x1); exp_ymin = VB'(y0); exp_ymax = VB'(y1);
`endif
   endtask

   task automatic fill(input bit v);
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = v;
   endtask

   task automatic make_square();
      fill(1'b0);
      for (int y = 30; y < 40; y++) for (int x = 20; x < 30; x++) img[y][x] = 1'b1;
   endtask

   task automatic make_random();
      int dens = $urandom_range(0, 40);
      int x0 = $urandom_range(0, W-1), y0 = $urandom_range(0, H-1);
      int rw = $urandom_range(1, 25), rh = $urandom_range(1, 40);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            img[y][x] = ($urandom_range(0, 99) < dens) ||
                        (x >= x0 && x < x0 + rw && y >= y0 && y < y0 + rh);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   int d0, ma, mp, mx0, mx1, my0, my1;

   initial begin
      cycles(3);
      check("rst_area", 32'(area_out), 32'd0);
      check("rst_perim", 32'(perimeter_out), 32'd0);
      check("rst_dv", 32'(data_valid_out), 32'd0);
      check("rst_overrun", 32'(overrun_out), 32'd0);
      rst_in = 1'b1; check_en = 1'b1;

      // All-zero frame
      fill(1'b0); d0 = dv_count;
      send_frame(0, 1'b0); cycles(5);
      check("zero_strobes", dv_count - d0, 1);
      check("zero_area", 32'(area_out), 32'd0);
      check("zero_perim", 32'(perimeter_out), 32'd0);

      // 10x10 square, strobe exactly two edges after the last pixel
      make_square(); model(ma, mp, mx0, mx1, my0, my1);
      check("model_sq_area", ma, 100);
      check("model_sq_perim", mp, 40);
      d0 = dv_count;
      send_frame(0, 1'b0);
      check("sq_dv_lat1", 32'(data_valid_out), 32'd0);
      cycles(1);
      check("sq_dv_lat2", 32'(data_valid_out), 32'd1);
      check("sq_area", 32'(area_out), 32'd100);
      check("sq_perim", 32'(perimeter_out), 32'd40);
      cycles(1);
      check("sq_dv_width", 32'(data_valid_out), 32'd0);
      cycles(3);
      check("sq_strobes", dv_count - d0, 1);

      // Full-ones frame
      fill(1'b1); d0 = dv_count;
      send_frame(0, 1'b0); cycles(5);
      check("full_strobes", dv_count - d0, 1);
      check("full_area", 32'(area_out), 32'd5304);
      check("full_perim", 32'(perimeter_out), 32'd308);

      // Single pixel with busy held for 50 cycles after the frame
      fill(1'b0); img[100][50] = 1'b1;
      model(ma, mp, mx0, mx1, my0, my1);
      check("model_px_perim", mp, 4);
      busy_in = 1'b1; d0 = dv_count;
      send_frame(0, 1'b0); cycles(50);
      check("busy_no_strobe", dv_count - d0, 0);
      busy_in = 1'b0;
      cycles(1);
      check("busy_release_dv", 32'(data_valid_out), 32'd1);
      cycles(3);
      check("busy_strobes", dv_count - d0, 1);
      check("px_area", 32'(area_out), 32'd1);
      check("px_perim", 32'(perimeter_out), 32'd4);
`ifdef BLOB_METRICS_BBOX_EN
      check("px_xmin", 32'(x_min_out), 32'd50);
      check("px_ymax", 32'(y_max_out), 32'd100);
`endif

      // Random frames with interleaved idle and out-of-range cycles
      for (int i = 0; i < 2; i++) begin
         make_random(); d0 = dv_count;
         send_frame(8, 1'b0); cycles(5);
         check("rand_strobes", dv_count - d0, 1);
      end

      // Second frame completes while the first is still pending
      busy_in = 1'b1; d0 = dv_count;
      make_random(); send_frame(5, 1'b0); cycles(5);
      make_random(); send_frame(5, 1'b1); cycles(5);
      check("ovr_no_strobe", dv_count - d0, 0);
      busy_in = 1'b0; cycles(4);
      check("ovr_strobes", dv_count - d0, 1);
      check("ovr_flag", 32'(overrun_out), 32'd1);

      // Reset mid-frame, then the remainder of that frame must not issue
      make_random();
      for (int y = 0; y < H/2; y++) for (int x = 0; x < W; x++) present(x, y, img[y][x], 1'b1);
      @(posedge clk_in); #1;
      rst_in = 1'b0; pixel_valid_in = 1'b0;
      exp_area = '0; exp_perim = '0; exp_overrun = 1'b0;
`ifdef BLOB_METRICS_BBOX_EN
      exp_xmin = '0; exp_xmax = '0; exp_ymin = '0; exp_ymax = '0;
`endif
      cycles(3);
      rst_in = 1'b1; d0 = dv_count;
      for (int y = H/2; y < H; y++) for (int x = 0; x < W; x++) present(x, y, img[y][x], 1'b1);
      @(posedge clk_in); #1; pixel_valid_in = 1'b0;
      cycles(5);
      check("abort_no_strobe", dv_count - d0, 0);
      make_square(); d0 = dv_count;
      send_frame(0, 1'b0); cycles(5);
      check("post_rst_strobes", dv_count - d0, 1);
      check("post_rst_area", 32'(area_out), 32'd100);
      check("post_rst_perim", 32'(perimeter_out), 32'd40);
      check("post_rst_overrun", 32'(overrun_out), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
